// File: rtl/gcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gcd_scheduler
// Purpose  : Round-robin scheduler that shares one GCD engine among N_REQ
//            requesters, with a watchdog that aborts jobs whose done never comes.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   a_in,
    input  logic [N_REQ*WIDTH-1:0]   b_in,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]         resp_gcd,
    output logic                     timeout,
    output logic                     busy,
    output logic                     gcd_start,
    output logic [WIDTH-1:0]         gcd_a,
    output logic [WIDTH-1:0]         gcd_b,
    input  logic                     gcd_done,
    input  logic [WIDTH-1:0]         gcd_result
);

    localparam int c_IDX_W = $clog2(N_REQ);
    localparam int c_WD_W  = $clog2(TIMEOUT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_owner;
    logic [c_IDX_W-1:0] r_last;
    logic [c_WD_W-1:0]  r_wdog;

    logic               w_found;
    logic [c_IDX_W-1:0] w_pick;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [N_REQ-1:0]   w_pick_oh;
    logic [N_REQ-1:0]   w_owner_oh;
    int                 w_dist;
    int                 w_best;

    // Rank each requester by its distance past the last owner; smallest wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_a     = '0;
        w_b     = '0;
        w_best  = N_REQ;
        w_dist  = 0;
        for (int j = 0; j < N_REQ; j++) begin
            w_dist = j - int'(r_last) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + N_REQ;
            end
            if (req[j] && (w_dist < w_best)) begin
                w_found = 1'b1;
                w_best  = w_dist;
                w_pick  = c_IDX_W'(j);
                w_a     = a_in[j*WIDTH +: WIDTH];
                w_b     = b_in[j*WIDTH +: WIDTH];
            end
        end
    end

    assign w_pick_oh  = N_REQ'(1) << w_pick;
    assign w_owner_oh = N_REQ'(1) << r_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_owner    <= '0;
            r_last     <= c_IDX_W'(N_REQ - 1);
            r_wdog     <= '0;
            grant      <= '0;
            resp_valid <= '0;
            resp_gcd   <= '0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
            gcd_start  <= 1'b0;
            gcd_a      <= '0;
            gcd_b      <= '0;
        end else begin
            grant      <= '0;
            gcd_start  <= 1'b0;
            resp_valid <= '0;
            timeout    <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_owner   <= w_pick;
                        gcd_a     <= w_a;
                        gcd_b     <= w_b;
                        grant     <= w_pick_oh;
                        gcd_start <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= c_START;
                    end
                end
                c_START: begin
                    r_wdog  <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    // Done wins over a watchdog expiry in the same cycle.
                    if (gcd_done) begin
                        resp_gcd   <= gcd_result;
                        resp_valid <= w_owner_oh;
                        r_state    <= c_RESP;
                    end else if (r_wdog == c_WD_W'(TIMEOUT - 2)) begin
                        resp_gcd   <= '0;
                        resp_valid <= w_owner_oh;
                        timeout    <= 1'b1;
                        r_state    <= c_RESP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                c_RESP: begin
                    r_last   <= r_owner;
                    resp_gcd <= '0;
                    busy     <= 1'b0;
                    r_state  <= c_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_scheduler
// Purpose  : Scoreboard bench for gcd_scheduler with a behavioural GCD engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_scheduler;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int IW      = $clog2(N_REQ);

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]       resp_gcd;
    logic                   timeout;
    logic                   busy;
    logic                   gcd_start;
    logic [WIDTH-1:0]       gcd_a;
    logic [WIDTH-1:0]       gcd_b;
    logic                   gcd_done;
    logic [WIDTH-1:0]       gcd_result;

    gcd_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .grant      (grant),
        .resp_valid (resp_valid),
        .resp_gcd   (resp_gcd),
        .timeout    (timeout),
        .busy       (busy),
        .gcd_start  (gcd_start),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result)
    );

    typedef struct {
        logic [IW-1:0] owner;
        int unsigned   val;
        bit            to;
        int            cyc;
    } exp_t;

    exp_t             sb[$];
    exp_t             m_e;
    logic [WIDTH-1:0] a_op[N_REQ];
    logic [WIDTH-1:0] b_op[N_REQ];
    bit               resp_flag[N_REQ];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               n_grant = 0;
    int               n_resp = 0;
    int               model_last = N_REQ - 1;
    int               forced_lat = -1;
    int               done_at = -1;
    int               m_pick;
    int               m_lat;
    logic [IW-1:0]    m_idx;
    logic [WIDTH-1:0] eng_res;
    logic [WIDTH-1:0] job_a;
    logic [WIDTH-1:0] job_b;
    bit               spur_en = 0;
    bit               spur_now = 0;
    bit               busy_next = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        a_in = '0;
        b_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            a_in[i*WIDTH +: WIDTH] = a_op[i];
            b_in[i*WIDTH +: WIDTH] = b_op[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (last + k) % N_REQ;
            if (r[idx[IW-1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return 1000;
        if (r == 1) return TIMEOUT - 1;
        return 1 + int'($urandom_range(0, 7));
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return WIDTH'($urandom_range(1, 12));
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // Monitor / scoreboard: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            busy_next = 0;
        end else begin
            if (busy_next) begin
                chk("busy_after_resp", 32'(busy), 32'd0);
                busy_next = 0;
            end
            if (grant != 0 || gcd_start) chk("start_with_grant", 32'(gcd_start), 32'(grant != 0));
            if (grant != 0) begin
                n_grant++;
                m_pick = rr_pick(req, model_last);
                if (m_pick < 0) begin
                    fail_now("grant_without_req");
                end else begin
                    m_idx = m_pick[IW-1:0];
                    chk("grant_owner", 32'(grant), 32'(1) << m_idx);
                    chk("gcd_a_capture", 32'(gcd_a), 32'(a_op[m_idx]));
                    chk("gcd_b_capture", 32'(gcd_b), 32'(b_op[m_idx]));
                    chk("busy_in_start", 32'(busy), 32'd1);
                    m_lat   = (forced_lat >= 0) ? forced_lat : rand_lat();
                    job_a   = a_op[m_idx];
                    job_b   = b_op[m_idx];
                    eng_res = WIDTH'(ref_gcd(32'(gcd_a), 32'(gcd_b)));
                    if (m_lat <= TIMEOUT - 1) begin
                        done_at = cyc + m_lat;
                        sb.push_back('{m_idx, ref_gcd(32'(job_a), 32'(job_b)), 1'b0, cyc + m_lat + 1});
                    end else begin
                        done_at = -1;
                        sb.push_back('{m_idx, 0, 1'b1, cyc + TIMEOUT});
                    end
                end
            end
            if (resp_valid != 0 || timeout) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    m_e = sb.pop_front();
                    chk("resp_valid_owner", 32'(resp_valid), 32'(1) << m_e.owner);
                    chk("resp_gcd", 32'(resp_gcd), m_e.val);
                    chk("resp_timeout", 32'(timeout), 32'(m_e.to));
                    chk("resp_cycle", 32'(cyc), 32'(m_e.cyc));
                    chk("gcd_a_held", 32'(gcd_a), 32'(job_a));
                    chk("gcd_b_held", 32'(gcd_b), 32'(job_b));
                    chk("busy_in_resp", 32'(busy), 32'd1);
                    model_last          = int'(m_e.owner);
                    resp_flag[m_e.owner] = 1;
                    n_resp++;
                    busy_next = 1;
                end
            end
        end
    end

    // Behavioural engine: done after the chosen latency, spurious pulses while idle.
    always @(negedge clk) begin
        if (done_at >= 0 && cyc == done_at) begin
            gcd_done   = 1'b1;
            gcd_result = eng_res;
        end else if (rst_n && !busy && (spur_now || (spur_en && $urandom_range(0, 7) == 0))) begin
            gcd_done   = 1'b1;
            gcd_result = WIDTH'($urandom);
            spur_now   = 0;
        end else begin
            gcd_done   = 1'b0;
            gcd_result = WIDTH'($urandom);
        end
    end

    task automatic wait_grant(input int target);
        int b = 0;
        while (n_grant < target && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (n_grant < target) fail_now("grant_wait_expired");
    endtask

    task automatic wait_resp(input int target);
        int b = 0;
        while (n_resp < target && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (n_resp < target) fail_now("resp_wait_expired");
    endtask

    task automatic drain();
        int b = 0;
        req = '0;
        while ((sb.size() != 0 || busy) && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (sb.size() != 0 || busy) fail_now("drain_expired");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"},      32'(grant),      32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_gcd"},   32'(resp_gcd),   32'd0);
        chk({tag, "_timeout"},    32'(timeout),    32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_gcd_start"},  32'(gcd_start),  32'd0);
        chk({tag, "_gcd_a"},      32'(gcd_a),      32'd0);
        chk({tag, "_gcd_b"},      32'(gcd_b),      32'd0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        req   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            a_op[i]      = '0;
            b_op[i]      = '0;
            resp_flag[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single job, engine latency 10.
        a_op[0] = 8'd12; b_op[0] = 8'd15; forced_lat = 10; req = 4'b0001;
        wait_grant(n_grant + 1);
        req = '0;
        wait_resp(n_resp + 1);

        // Contention between requesters 0 and 2, twice.
        forced_lat = -1;
        a_op[0] = 8'd1; b_op[0] = 8'd8; a_op[2] = 8'd0; b_op[2] = 8'd0;
        for (int r = 0; r < 2; r++) begin
            base = n_resp;
            req = 4'b0101;
            wait_grant(n_grant + 2);
            req = '0;
            wait_resp(base + 2);
        end

        // All requesters held for 8 jobs.
        for (int i = 0; i < N_REQ; i++) begin
            a_op[i] = rand_op();
            b_op[i] = rand_op();
        end
        base = n_resp;
        req = '1;
        wait_grant(n_grant + 8);
        req = '0;
        wait_resp(base + 8);

        // Watchdog expiry, then done exactly on the last waiting cycle.
        a_op[1] = 8'd36; b_op[1] = 8'd48; forced_lat = 1000; req = 4'b0010;
        wait_grant(n_grant + 1);
        req = '0;
        wait_resp(n_resp + 1);
        a_op[3] = 8'd49; b_op[3] = 8'd21; forced_lat = TIMEOUT - 1; req = 4'b1000;
        wait_grant(n_grant + 1);
        req = '0;
        wait_resp(n_resp + 1);
        forced_lat = -1;

        // Spurious done pulses while idle.
        base = n_resp;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            spur_now = 1;
            repeat (4) @(negedge clk);
        end
        chk("spurious_done_ignored", 32'(n_resp), 32'(base));

        // Randomized traffic.
        for (int i = 0; i < N_REQ; i++) resp_flag[i] = 0;
        spur_en = 1;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        a_op[i] = rand_op();
                        b_op[i] = rand_op();
                        req[i]  = 1'b1;
                    end
                end else if (resp_flag[i]) begin
                    resp_flag[i] = 0;
                    if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
                end else if ($urandom_range(0, 31) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        spur_en = 0;
        drain();

        // Reset in the middle of a waiting job.
        @(negedge clk);
        a_op[0] = 8'd12; b_op[0] = 8'd15; forced_lat = 1000; req = 4'b0001;
        wait_grant(n_grant + 1);
        req = '0;
        repeat (5) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'd1);
        base = n_resp;
        rst_n = 1'b0;
        done_at = -1;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        model_last = N_REQ - 1;
        repeat (5) @(negedge clk);
        for (int i = 1; i < N_REQ; i++) begin
            a_op[i] = rand_op();
            b_op[i] = rand_op();
        end
        forced_lat = 3;
        req = '1;
        rst_n = 1'b1;
        wait_grant(n_grant + 1);
        chk("post_reset_first_grant", 32'(grant), 32'd1);
        req = '0;
        wait_resp(base + 1);
        forced_lat = -1;
        drain();
        repeat (80) @(negedge clk);
        chk("no_stale_resp", 32'(n_resp), 32'(base + 1));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
